// File: rtl/period_capture_pkg.sv
// Shared types and constants for the period_capture block and its input conditioner.
package period_capture_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned DEBOUNCE_LEN    = 4;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  // Fewer than two stages gives no metastability protection, so round up silently.
  function automatic int unsigned clamp_stages(input int unsigned stages);
    return (stages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : stages;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Synchronizes an asynchronous pin and emits a one-cycle pulse on each rising edge.
// Build option PERIOD_CAPTURE_DEBOUNCE_EN inserts a DEBOUNCE_LEN-cycle glitch filter.
module pin_sync_edge
  import period_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic pin,
  output logic rise
);

  localparam int unsigned Stages = clamp_stages(SYNC_STAGES);

  logic [Stages-1:0] sync_q;
  logic              sync_out;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], pin};
    end
  end

  assign sync_out = sync_q[Stages-1];

`ifdef PERIOD_CAPTURE_DEBOUNCE_EN
  logic [DEBOUNCE_LEN-2:0] hist_q;
  logic [DEBOUNCE_LEN-1:0] window;
  logic                    filt_q;
  logic                    filt_d;

  assign window = {hist_q, sync_out};

  // Level moves only once the whole window agrees on the new value.
  always_comb begin
    filt_d = filt_q;
    if (&window) begin
      filt_d = 1'b1;
    end else if (~|window) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= window[DEBOUNCE_LEN-2:0];
      filt_q <= filt_d;
    end
  end

  assign rise = filt_d & ~filt_q;
`else
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_out;
    end
  end

  assign rise = sync_out & ~prev_q;
`endif

endmodule

// File: rtl/period_capture.sv
// Measures the period of an external pin in CLK cycles, rising edge to rising edge,
// and hands each result over a valid/ready interface with overflow and drop flags.
module period_capture
  import period_capture_pkg::*;
#(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             I,
  output logic [WIDTH-1:0] O,
  output logic             VALID,
  input  logic             READY,
  output logic             OVF,
  output logic             DROP
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic             rise;
  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             sat_q;
  logic [WIDTH-1:0] o_q;
  logic             valid_q;
  logic             ovf_q;
  logic             drop_q;
  logic             capture_ok;

  pin_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync_edge (
    .clk   (CLK),
    .resetb(RESETB),
    .pin   (I),
    .rise  (rise)
  );

  // A consume in the same cycle frees the holding register for the new value.
  assign capture_ok = !valid_q || READY;

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      o_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (valid_q && READY) begin
        valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise) begin
            state_q <= MEASURE;
            cnt_q   <= WIDTH'(1);
            sat_q   <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (capture_ok) begin
              o_q     <= cnt_q;
              ovf_q   <= sat_q;
              valid_q <= 1'b1;
            end else begin
              drop_q <= 1'b1;
            end
            cnt_q <= WIDTH'(1);
            sat_q <= 1'b0;
          end else if (cnt_q == CntMax) begin
            sat_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign O     = o_q;
  assign VALID = valid_q;
  assign OVF   = ovf_q;
  assign DROP  = drop_q;

endmodule

// File: tb/tb_period_capture.sv
// Bench for period_capture: directed scenarios plus random pin/ready/reset traffic, checked
// every cycle against a period model for a 26-bit and a 4-bit instance.
module tb_period_capture;

  localparam int SyncStages = 2;
`ifdef PERIOD_CAPTURE_DEBOUNCE_EN
  localparam int CapOff = SyncStages + 3;
`else
  localparam int CapOff = SyncStages;
`endif
  localparam int MaxC = 8192;

  logic        clk    = 1'b0;
  logic        resetb = 1'b0;
  logic        pin    = 1'b0;
  logic        ready  = 1'b0;
  logic [25:0] o_a;
  logic        valid_a, ovf_a, drop_a;
  logic [3:0]  o_b;
  logic        valid_b, ovf_b, drop_b;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = WIDTH 26, index 1 = WIDTH 4.
  bit samp[MaxC];
  bit filt[MaxC];
  int n = 16;
  int m_o[2];
  int m_last[2];
  int m_max[2];
  bit m_vld[2], m_ovf[2], m_drop[2];

  period_capture #(.WIDTH(26), .SYNC_STAGES(SyncStages)) dut (
    .CLK(clk), .RESETB(resetb), .I(pin), .O(o_a), .VALID(valid_a), .READY(ready),
    .OVF(ovf_a), .DROP(drop_a)
  );

  period_capture #(.WIDTH(4), .SYNC_STAGES(SyncStages)) dut4 (
    .CLK(clk), .RESETB(resetb), .I(pin), .O(o_b), .VALID(valid_b), .READY(ready),
    .OVF(ovf_b), .DROP(drop_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rising edge of the (optionally filtered) pin level at sample index j.
  function automatic bit edge_at(input int j);
    if (j < 1) return 1'b0;
`ifdef PERIOD_CAPTURE_DEBOUNCE_EN
    return filt[j] & ~filt[j-1];
`else
    return samp[j] & ~samp[j-1];
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_o[k] = 0; m_last[k] = -1; m_vld[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
    end
  endtask

  task automatic tick(input bit p, input bit r, input bit rb);
    bit ev, all1, all0, ok;
    int per;
    @(negedge clk);
    pin = p; ready = r; resetb = rb;
    @(posedge clk);
    n++;
    if (n >= MaxC) begin
      $display("FAIL sample_budget observed=%0d expected<%0d", n, MaxC);
      $fatal(1);
    end
    if (!rb) begin
      for (int j = n - 16; j <= n; j++) begin
        samp[j] = 0; filt[j] = 0;
      end
      model_reset();
    end else begin
      samp[n] = p;
      all1 = samp[n] & samp[n-1] & samp[n-2] & samp[n-3];
      all0 = !(samp[n] | samp[n-1] | samp[n-2] | samp[n-3]);
      filt[n] = all1 ? 1'b1 : (all0 ? 1'b0 : filt[n-1]);
      ev = edge_at(n - SyncStages);
      for (int k = 0; k < 2; k++) begin
        ok = !m_vld[k] || r;
        if (m_vld[k] && r) m_vld[k] = 0;
        if (ev) begin
          if (m_last[k] >= 0) begin
            per = n - m_last[k];
            if (ok) begin
              m_o[k] = (per > m_max[k]) ? m_max[k] : per;
              m_ovf[k] = per > m_max[k];
              m_vld[k] = 1;
            end else begin
              m_drop[k] = 1;
            end
          end
          m_last[k] = n;
        end
      end
    end
    #1;
    chk("o_w26", 32'(o_a), m_o[0]);
    chk("valid_w26", 32'(valid_a), 32'(m_vld[0]));
    chk("ovf_w26", 32'(ovf_a), 32'(m_ovf[0]));
    chk("drop_w26", 32'(drop_a), 32'(m_drop[0]));
    chk("o_w4", 32'(o_b), m_o[1]);
    chk("valid_w4", 32'(valid_b), 32'(m_vld[1]));
    chk("ovf_w4", 32'(ovf_b), 32'(m_ovf[1]));
    chk("drop_w4", 32'(drop_b), 32'(m_drop[1]));
  endtask

  task automatic pulse_train(input int period, input int high, input int count, input bit r);
    for (int c = 0; c < count; c++)
      for (int i = 0; i < period; i++) tick(i < high, r, 1'b1);
  endtask

  initial begin
    int vcount;
    int left;
    bit p;
    m_max[0] = (1 << 26) - 1;
    m_max[1] = 15;
    model_reset();

    // Reset state
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("rst_o", 32'(o_a), 0);
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_drop", 32'(drop_a), 0);

    // Period 10 square wave, always ready
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    pulse_train(10, 5, 6, 1'b1);
    repeat (8) tick(1'b0, 1'b1, 1'b1);
    chk("p10_o", 32'(o_a), 10);
    chk("p10_ovf", 32'(ovf_a), 0);

    // Consumer stalled: first result held, third edge drops
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    pulse_train(16, 8, 3, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    chk("stall_valid", 32'(valid_a), 1);
    chk("stall_o", 32'(o_a), 16);
    chk("stall_drop", 32'(drop_a), 1);
    tick(1'b0, 1'b1, 1'b1);
    chk("stall_consumed", 32'(valid_a), 0);
    tick(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a measurement
    pulse_train(16, 8, 1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("midrst_o", 32'(o_a), 0);
    chk("midrst_valid", 32'(valid_a), 0);
    chk("midrst_drop", 32'(drop_a), 0);
    pulse_train(9, 4, 1, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b1);
    chk("midrst_first_edge", 32'(valid_a), 0);
    pulse_train(9, 4, 1, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b1);
    chk("midrst_second_valid", 32'(valid_a), 1);
    chk("midrst_second_o", 32'(o_a), 15);

    // Saturation on the 4-bit instance
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    pulse_train(20, 10, 2, 1'b1);
    chk("sat_o_w4", 32'(o_b), 15);
    chk("sat_ovf_w4", 32'(ovf_b), 1);
    chk("sat_o_w26", 32'(o_a), 20);
    pulse_train(8, 4, 2, 1'b1);
    repeat (8) tick(1'b0, 1'b1, 1'b1);
    chk("unsat_o_w4", 32'(o_b), 8);
    chk("unsat_ovf_w4", 32'(ovf_b), 0);

    // Consume and capture in the same cycle
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    pulse_train(12, 6, 2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(i < 6, i == CapOff, 1'b1);
      if (i == CapOff) begin
        chk("simul_valid", 32'(valid_a), 1);
        chk("simul_o", 32'(o_a), 12);
        chk("simul_drop", 32'(drop_a), 0);
      end
    end

    // Period-20 wave with 2-cycle glitches mid-period
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    vcount = 0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 20; i++) begin
        tick((i < 5) || (i >= 10 && i < 12), 1'b1, 1'b1);
        if (valid_a) vcount++;
      end
    end
    repeat (10) begin
      tick(1'b0, 1'b1, 1'b1);
      if (valid_a) vcount++;
    end
`ifdef PERIOD_CAPTURE_DEBOUNCE_EN
    chk("glitch_o", 32'(o_a), 20);
    chk("glitch_valids", 32'(vcount), 4);
`else
    chk("glitch_o", 32'(o_a), 10);
    chk("glitch_valids", 32'(vcount), 9);
`endif

    // Random pin runs, random ready, rare resets
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    left = 0;
    p = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (left == 0) begin
        p = ~p;
        left = $urandom_range(1, 14);
      end
      left--;
      tick(p, $urandom_range(0, 2) != 0, $urandom_range(0, 399) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
